// File: rtl/icache_dm.sv
// icache_dm -- direct-mapped, blocking instruction cache.
//
// 256 sets x 1 way x 16-byte lines. A request is accepted in IDLE, looked up
// one cycle later, and on a miss (or an uncached request) a line (or a single
// word) is read from memory before the response is returned.
//
// Handshakes:
//   fetch side : valid/addr_ok -- a request transfers in the cycle where
//                valid && addr_ok; the response is a one-cycle data_ok pulse
//                carrying rdata (there is no backpressure on the response).
//   read req   : rd_req/rd_rdy -- rd_req with rd_type/rd_addr stays asserted
//                and stable until the cycle rd_rdy is high; that cycle is the
//                transfer.
//   read data  : ret_valid/ret_last -- one beat per ret_valid cycle, no
//                backpressure; ret_last marks the final beat.
//
// Ports:
//   clk, resetn             clock, synchronous active-low reset
//   valid, op, index, tag,  fetch request (op=1 writes are answered with
//   offset, wstrb, wdata,   rdata=0 and otherwise ignored; wstrb/wdata
//   uncache                 unused)
//   addr_ok, data_ok, rdata request accept / response
//   rd_req, rd_type,        memory read request (3'b100 line, 3'b010 word)
//   rd_addr, rd_rdy
//   ret_valid, ret_last,    memory read return beats
//   ret_data
//   dbg_state               current FSM state (IDLE=0 LOOKUP=1 MISS=2 REFILL=3)
//   hit_cnt, miss_cnt       cached lookup hit/miss counters, present only
//                           when ICACHE_STAT_EN is defined
module icache_dm (
  input  logic        clk,
  input  logic        resetn,
  input  logic        valid,
  input  logic        op,
  input  logic [7:0]  index,
  input  logic [19:0] tag,
  input  logic [3:0]  offset,
  input  logic [3:0]  wstrb,
  input  logic [31:0] wdata,
  input  logic        uncache,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  output logic        rd_req,
  output logic [2:0]  rd_type,
  output logic [31:0] rd_addr,
  input  logic        rd_rdy,
  input  logic        ret_valid,
  input  logic        ret_last,
  input  logic [31:0] ret_data,
  output logic [1:0]  dbg_state
`ifdef ICACHE_STAT_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  typedef enum logic [1:0] {IDLE = 2'd0, LOOKUP = 2'd1, MISS = 2'd2, REFILL = 2'd3} state_t;

  state_t state, state_nxt;

  // latched request
  logic        op_r;
  logic [7:0]  index_r;
  logic [19:0] tag_r;
  logic [3:0]  offset_r;
  logic        uncache_r;

  // storage
  logic [255:0] valid_arr;
  logic [19:0]  tag_arr  [256];
  logic [31:0]  data_arr [256][4];

  logic [1:0]  beat_cnt;
  logic [31:0] word_buf;   // requested word captured while the line streams in
  logic [1:0]  word_sel;
  logic        hit;

  logic unused_ok;
  assign unused_ok = ^{wstrb, wdata};

  assign word_sel  = offset_r[3:2];
  assign hit       = valid_arr[index_r] && (tag_arr[index_r] == tag_r);
  assign rd_type   = uncache_r ? 3'b010 : 3'b100;
  assign rd_addr   = uncache_r ? {tag_r, index_r, offset_r} : {tag_r, index_r, 4'b0000};
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    addr_ok   = 1'b0;
    data_ok   = 1'b0;
    rdata     = 32'h0;
    rd_req    = 1'b0;
    case (state)
      IDLE: begin
        addr_ok = valid;
        if (valid) state_nxt = LOOKUP;
      end
      LOOKUP: begin
        if (op_r) begin
          data_ok   = 1'b1;
          state_nxt = IDLE;
        end else if (!uncache_r && hit) begin
          data_ok   = 1'b1;
          rdata     = data_arr[index_r][word_sel];
          state_nxt = IDLE;
        end else begin
          state_nxt = MISS;
        end
      end
      MISS: begin
        rd_req = 1'b1;
        if (rd_rdy) state_nxt = REFILL;
      end
      REFILL: begin
        if (ret_valid && ret_last) begin
          data_ok = 1'b1;
          // the requested word may be arriving on this very beat
          if (uncache_r || beat_cnt == word_sel) rdata = ret_data;
          else                                   rdata = word_buf;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // outputs are quiet during reset, whatever state is still registered
    if (!resetn) begin
      addr_ok   = 1'b0;
      data_ok   = 1'b0;
      rd_req    = 1'b0;
      state_nxt = IDLE;
    end
  end

  // request latch
  always_ff @(posedge clk) begin
    if (resetn && state == IDLE && valid) begin
      op_r      <= op;
      index_r   <= index;
      tag_r     <= tag;
      offset_r  <= offset;
      uncache_r <= uncache;
    end
  end

  // valid bits and beat counter
  always_ff @(posedge clk) begin
    if (!resetn) begin
      valid_arr <= '0;
      beat_cnt  <= 2'd0;
    end else begin
      if (state == MISS) beat_cnt <= 2'd0;
      if (state == REFILL && ret_valid) begin
        beat_cnt <= beat_cnt + 2'd1;
        if (ret_last && !uncache_r) valid_arr[index_r] <= 1'b1;
      end
    end
  end

  // data/tag arrays and requested-word buffer (not reset)
  always_ff @(posedge clk) begin
    if (resetn && state == REFILL && ret_valid) begin
      if (beat_cnt == word_sel) word_buf <= ret_data;
      if (!uncache_r) begin
        data_arr[index_r][beat_cnt] <= ret_data;
        if (ret_last) tag_arr[index_r] <= tag_r;
      end
    end
  end

`ifdef ICACHE_STAT_EN
  always_ff @(posedge clk) begin
    if (!resetn) begin
      hit_cnt  <= 32'd0;
      miss_cnt <= 32'd0;
    end else if (state == LOOKUP && !op_r && !uncache_r) begin
      if (hit) hit_cnt  <= hit_cnt + 32'd1;
      else     miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm. Each request pushes its expected rdata to a
// queue; the queue is popped when data_ok is seen. Inputs are driven 1 ns
// after the rising edge and outputs sampled 1 ns later.
module tb_icache_dm;

  logic        clk;
  logic        resetn;
  logic        valid;
  logic        op;
  logic [7:0]  index;
  logic [19:0] tag;
  logic [3:0]  offset;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        uncache;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;
  logic        rd_req;
  logic [2:0]  rd_type;
  logic [31:0] rd_addr;
  logic        rd_rdy;
  logic        ret_valid;
  logic        ret_last;
  logic [31:0] ret_data;
  logic [1:0]  dbg_state;
`ifdef ICACHE_STAT_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  icache_dm dut (
    .clk       (clk),
    .resetn    (resetn),
    .valid     (valid),
    .op        (op),
    .index     (index),
    .tag       (tag),
    .offset    (offset),
    .wstrb     (wstrb),
    .wdata     (wdata),
    .uncache   (uncache),
    .addr_ok   (addr_ok),
    .data_ok   (data_ok),
    .rdata     (rdata),
    .rd_req    (rd_req),
    .rd_type   (rd_type),
    .rd_addr   (rd_addr),
    .rd_rdy    (rd_rdy),
    .ret_valid (ret_valid),
    .ret_last  (ret_last),
    .ret_data  (ret_data),
    .dbg_state (dbg_state)
`ifdef ICACHE_STAT_EN
    ,
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  int n_asserts = 0;
  int n_fail    = 0;
  logic [31:0] exp_q[$];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  // scoreboard: response seen now, compare against oldest expectation
  task automatic resp(input string name);
    logic [31:0] e;
    chk({name, "_data_ok"}, {31'd0, data_ok}, 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({name, "_rdata"}, rdata, e);
    end else begin
      n_asserts++;
      n_fail++;
      $error("FAIL %s_sb: observed response expected none queued", name);
    end
  endtask

  // one complete request; beats are served only when a miss is expected
  task automatic txn(input string nm, input logic o, input logic unc,
                     input logic [7:0] idx, input logic [19:0] tg, input logic [3:0] off,
                     input logic exp_hit, input logic [2:0] exp_type, input logic [31:0] exp_addr,
                     input int nbeats, input logic [31:0] b0, input logic [31:0] b1,
                     input logic [31:0] b2, input logic [31:0] b3, input logic [31:0] exp_data);
    logic [31:0] beats [4];
    beats[0] = b0; beats[1] = b1; beats[2] = b2; beats[3] = b3;
    exp_q.push_back(exp_data);
    valid = 1'b1; op = o; uncache = unc; index = idx; tag = tg; offset = off;
    wstrb = 4'($urandom_range(0, 15)); wdata = $urandom;
    #1;
    chk({nm, "_addr_ok"}, {31'd0, addr_ok}, 32'd1);
    tick;
    valid = 1'b0;
    #1;
    if (exp_hit) begin
      chk({nm, "_hit_rd_req"}, {31'd0, rd_req}, 32'd0);
      resp(nm);
      tick;
    end else begin
      chk({nm, "_lookup_data_ok"}, {31'd0, data_ok}, 32'd0);
      tick;
      #1;
      chk({nm, "_rd_req"}, {31'd0, rd_req}, 32'd1);
      chk({nm, "_rd_type"}, {29'd0, rd_type}, {29'd0, exp_type});
      chk({nm, "_rd_addr"}, rd_addr, exp_addr);
      tick;
      #1;
      chk({nm, "_rd_req_held"}, {31'd0, rd_req}, 32'd1);
      rd_rdy = 1'b1;
      tick;
      rd_rdy = 1'b0;
      for (int i = 0; i < nbeats; i++) begin
        ret_valid = 1'b1;
        ret_data  = beats[i];
        ret_last  = (i == nbeats - 1);
        #1;
        if (i == nbeats - 1) resp(nm);
        else chk({nm, "_beat_data_ok"}, {31'd0, data_ok}, 32'd0);
        tick;
      end
      ret_valid = 1'b0;
      ret_last  = 1'b0;
    end
  endtask

  initial begin
    resetn = 1'b0; valid = 1'b1; op = 1'b0; index = 8'h0; tag = 20'h0; offset = 4'h0;
    wstrb = 4'h0; wdata = 32'h0; uncache = 1'b0; rd_rdy = 1'b0;
    ret_valid = 1'b0; ret_last = 1'b0; ret_data = 32'h0;
    repeat (3) tick;
    #1;
    chk("rst_addr_ok", {31'd0, addr_ok}, 32'd0);
    chk("rst_data_ok", {31'd0, data_ok}, 32'd0);
    chk("rst_rd_req", {31'd0, rd_req}, 32'd0);
    chk("rst_state", {30'd0, dbg_state}, 32'd0);
    valid = 1'b0;
    resetn = 1'b1;
    tick;

    // cold miss, requested word is a buffered beat
    txn("cold", 1'b0, 1'b0, 8'h00, 20'h1C000, 4'h4, 1'b0, 3'b100, 32'h1C000000,
        4, 32'h11, 32'h22, 32'h33, 32'h44, 32'h22);
    // back-to-back hit on the same line
    txn("hit", 1'b0, 1'b0, 8'h00, 20'h1C000, 4'hC, 1'b1, 3'b100, 32'h0,
        0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h44);
    // write is answered with zero and touches nothing
    txn("write", 1'b1, 1'b0, 8'h00, 20'h1C000, 4'h4, 1'b1, 3'b100, 32'h0,
        0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
`ifdef ICACHE_STAT_EN
    chk("hit_cnt", hit_cnt, 32'd1);
    chk("miss_cnt", miss_cnt, 32'd1);
`endif
    // line still resident after the write
    txn("hit2", 1'b0, 1'b0, 8'h00, 20'h1C000, 4'h0, 1'b1, 3'b100, 32'h0,
        0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h11);

    // uncached, twice: both go to memory
    txn("unc1", 1'b0, 1'b1, 8'h12, 20'hBFAF0, 4'h8, 1'b0, 3'b010, 32'hBFAF0128,
        1, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 32'hDEADBEEF);
    txn("unc2", 1'b0, 1'b1, 8'h12, 20'hBFAF0, 4'h8, 1'b0, 3'b010, 32'hBFAF0128,
        1, 32'hCAFEF00D, 32'h0, 32'h0, 32'h0, 32'hCAFEF00D);

    // conflict on set 5
    txn("cf_a", 1'b0, 1'b0, 8'h05, 20'h1C000, 4'h0, 1'b0, 3'b100, 32'h1C000050,
        4, 32'h51, 32'h52, 32'h53, 32'h54, 32'h51);
    txn("cf_b", 1'b0, 1'b0, 8'h05, 20'h1C001, 4'hC, 1'b0, 3'b100, 32'h1C001050,
        4, 32'h61, 32'h62, 32'h63, 32'h64, 32'h64);
    txn("cf_a2", 1'b0, 1'b0, 8'h05, 20'h1C000, 4'h4, 1'b0, 3'b100, 32'h1C000050,
        4, 32'h51, 32'h52, 32'h53, 32'h54, 32'h52);
    txn("cf_hit", 1'b0, 1'b0, 8'h05, 20'h1C000, 4'h8, 1'b1, 3'b100, 32'h0,
        0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h53);

    // reset in the middle of a refill; remaining beats keep coming
    valid = 1'b1; op = 1'b0; uncache = 1'b0; index = 8'h33; tag = 20'h12345; offset = 4'h4;
    #1;
    chk("rr_addr_ok", {31'd0, addr_ok}, 32'd1);
    tick;
    valid = 1'b0;
    tick;
    #1;
    chk("rr_rd_addr", rd_addr, 32'h12345330);
    rd_rdy = 1'b1;
    tick;
    rd_rdy = 1'b0;
    ret_valid = 1'b1; ret_last = 1'b0; ret_data = 32'hA0;
    #1;
    chk("rr_beat0", {31'd0, data_ok}, 32'd0);
    tick;
    resetn = 1'b0; ret_data = 32'hA1;
    #1;
    chk("rr_rst_data_ok", {31'd0, data_ok}, 32'd0);
    chk("rr_rst_rd_req", {31'd0, rd_req}, 32'd0);
    tick;
    resetn = 1'b1; ret_data = 32'hA2;
    #1;
    chk("rr_state", {30'd0, dbg_state}, 32'd0);
    chk("rr_beat2", {31'd0, data_ok}, 32'd0);
    tick;
    ret_data = 32'hA3; ret_last = 1'b1;
    #1;
    chk("rr_stray_last", {31'd0, data_ok}, 32'd0);
    tick;
    ret_valid = 1'b0; ret_last = 1'b0;
    #1;
    chk("rr_idle", {30'd0, dbg_state}, 32'd0);

    // valid bits cleared: formerly resident line and aborted address both miss
    txn("post_rst_a", 1'b0, 1'b0, 8'h00, 20'h1C000, 4'h4, 1'b0, 3'b100, 32'h1C000000,
        4, 32'h11, 32'h22, 32'h33, 32'h44, 32'h22);
    txn("post_rst_b", 1'b0, 1'b0, 8'h33, 20'h12345, 4'h4, 1'b0, 3'b100, 32'h12345330,
        4, 32'hB0, 32'hB1, 32'hB2, 32'hB3, 32'hB1);
`ifdef ICACHE_STAT_EN
    chk("hit_cnt_post", hit_cnt, 32'd0);
    chk("miss_cnt_post", miss_cnt, 32'd2);
`endif

    chk("sb_drain", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/icache_dm.md
ICACHE_DM -- requirements
Module: icache_dm

Interface
REQ-001 SHALL have port: clk  input  1  clock; all state updates on rising edge.
REQ-002 SHALL have port: resetn  input  1  reset; synchronous, active-low.
REQ-003 SHALL have port: valid  input  1  request from fetch unit.
REQ-004 SHALL have port: op  input  1  0=read; 1=write (unsupported, see REQ-019).
REQ-005 SHALL have port: index  input  8  set index (VA[11:4]).
REQ-006 SHALL have port: tag  input  20  physical tag (PA[31:12]).
REQ-007 SHALL have port: offset  input  4  byte offset in line; [3:2] selects word.
REQ-008 SHALL have ports: wstrb  input  4, wdata  input  32; ignored.
REQ-009 SHALL have port: uncache  input  1  bypass cache, single-word memory read.
REQ-010 SHALL have port: addr_ok  output  1  request accepted this cycle.
REQ-011 SHALL have ports: data_ok  output  1, rdata  output  32  one-cycle response pulse with instruction word.
REQ-012 SHALL have ports: rd_req  output  1, rd_type  output  3 (3'b100 line, 3'b010 word), rd_addr  output  32, rd_rdy  input  1.
REQ-013 SHALL have ports: ret_valid  input  1, ret_last  input  1, ret_data  input  32.

Function
REQ-014 SHALL hold 256 sets, 1 way, 16-byte lines: per set valid bit, 20-bit tag, four 32-bit words.
REQ-015 SHALL implement states IDLE, LOOKUP, MISS, REFILL.
REQ-016 IDLE: addr_ok = valid (combinational); on valid, SHALL latch op, index, tag, offset, uncache and go to LOOKUP; no other state asserts addr_ok.
REQ-017 LOOKUP, cached and valid[index] && tag match: data_ok=1, rdata=word[offset[3:2]], next IDLE (hit latency: data_ok one cycle after addr_ok).
REQ-018 LOOKUP, miss or uncache: data_ok=0, next MISS.
REQ-019 LOOKUP with latched op=1: data_ok=1, rdata=0, no array or bus activity, next IDLE.
REQ-020 MISS: rd_req=1; cached rd_type=3'b100, rd_addr={tag,index,4'b0}; uncached rd_type=3'b010, rd_addr={tag,index,offset}; rd_req held until rd_rdy, then REFILL.
REQ-021 REFILL: 2-bit beat counter from 0, incremented per ret_valid; cached beats written into set words 0..3 in order; ret_valid outside REFILL ignored.
REQ-022 REFILL, ret_valid && ret_last: data_ok=1 same cycle; rdata = requested word (ret_data if this is its beat, else buffered word); cached: set valid=1, tag written; uncached: set untouched, rdata=ret_data; next IDLE.
REQ-023 Line update SHALL be visible to a LOOKUP in the cycle after the REFILL-to-IDLE transition (hit on back-to-back same line).
REQ-024 Outputs rd_req, data_ok SHALL be 0 in every state not listed above; rdata undefined when data_ok=0.

Reset
REQ-025 resetn low SHALL force IDLE, clear all 256 valid bits, clear beat counter; data/tag arrays not reset.
REQ-026 Reset mid-MISS/REFILL SHALL abandon the transfer; no data_ok issued; subsequent stray ret_valid ignored in IDLE.
REQ-027 During reset addr_ok, data_ok, rd_req SHALL be 0.

Configuration
REQ-028 Macro ICACHE_STAT_EN defined: SHALL add outputs hit_cnt 32 and miss_cnt 32, incremented on cached LOOKUP hit / miss respectively, wrapping at 2^32, cleared by reset; uncached and op=1 requests not counted.
REQ-029 ICACHE_STAT_EN undefined: counters and ports absent; behaviour otherwise identical.

Verification
REQ-030 Cold miss: read tag=0x1C000, index=0x00, offset=0x4 -> rd_req type 3'b100 addr 0x1C000000; return beats 0x11,0x22,0x33,0x44 (last) -> data_ok with rdata 0x22.
REQ-031 Following hit: same tag/index, offset=0xC -> data_ok one cycle after addr_ok, rdata 0x44, rd_req stays 0.
REQ-032 Uncached: tag=0xBFAF0, index=0x12, offset=0x8, uncache=1 -> rd_type 3'b010, rd_addr 0xBFAF0128; beat 0xDEADBEEF (last) -> rdata 0xDEADBEEF; repeat request misses again.
REQ-033 Conflict: fill tag 0x1C000 index 5, then tag 0x1C001 index 5 -> second misses and refills; first then misses again.
REQ-034 Reset after rd_rdy mid-REFILL, remaining beats still driven -> no data_ok, valid bits 0, next read at same address misses.
REQ-035 With ICACHE_STAT_EN: scenarios REQ-030 then REQ-031 -> hit_cnt=1, miss_cnt=1.
